// File: rtl/nx_stream_arbiter.sv
// Round-robin stream arbiter with burst locking and a single registered egress slot.
// A winner keeps the grant for up to MAX_BURST consecutive transfers, then the grant rotates.
module nx_stream_arbiter #(
    parameter int unsigned STREAM_WIDTH = 32,
    parameter int unsigned INPUTS       = 4,
    parameter int unsigned MAX_BURST    = 4
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic [INPUTS*STREAM_WIDTH-1:0] in_data_i,
    input  logic [INPUTS*2-1:0]            in_dir_i,
    input  logic [INPUTS-1:0]              in_valid_i,
    output logic [INPUTS-1:0]              in_ready_o,
    input  logic [INPUTS-1:0]              mask_i,
    output logic [STREAM_WIDTH-1:0]        arb_data_o,
    output logic [1:0]                     arb_dir_o,
    output logic                           arb_valid_o,
    input  logic                           arb_ready_i,
    output logic [$clog2(INPUTS)-1:0]      grant_o
);

    localparam int unsigned GW = $clog2(INPUTS);
    localparam int unsigned CW = $clog2(MAX_BURST + 1);

    logic [GW-1:0]           owner;
    logic [CW-1:0]           cnt;
    logic                    slot_valid;
    logic [STREAM_WIDTH-1:0] slot_data;
    logic [1:0]              slot_dir;

    logic [INPUTS-1:0] req;
    logic              any_req;
    logic              accept;
    logic              lock;
    logic              xfer;
    logic              found;
    logic [GW-1:0]     cand;
    logic [GW-1:0]     sel;

    assign req     = in_valid_i & mask_i;
    assign any_req = |req;
    assign accept  = !slot_valid || arb_ready_i;
    assign lock    = req[owner] && (cnt != '0) && (cnt < CW'(MAX_BURST));
    assign xfer    = accept && any_req;

    // Search starts at owner+1 so the current owner is considered last.
    always_comb begin
        sel   = owner;
        found = 1'b0;
        cand  = '0;
        for (int unsigned k = 1; k <= INPUTS; k++) begin
            cand = GW'((32'(owner) + k) % INPUTS);
            if (!found && req[cand]) begin
                sel   = cand;
                found = 1'b1;
            end
        end
        if (lock) begin
            sel = owner;
        end
    end

    always_comb begin
        in_ready_o = '0;
        if (!rst_i && xfer) begin
            in_ready_o[sel] = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            slot_valid <= 1'b0;
            slot_data  <= '0;
            slot_dir   <= '0;
            owner      <= GW'(INPUTS - 1);
            cnt        <= '0;
        end else if (xfer) begin
            slot_valid <= 1'b1;
            slot_data  <= in_data_i[32'(sel)*STREAM_WIDTH +: STREAM_WIDTH];
            slot_dir   <= in_dir_i[32'(sel)*2 +: 2];
            owner      <= sel;
            cnt        <= lock ? cnt + CW'(1) : CW'(1);
        end else begin
            if (accept) begin
                slot_valid <= 1'b0;
            end
            // Owner not requesting releases the burst even while the slot is stalled.
            if (!req[owner]) begin
                cnt <= '0;
            end
        end
    end

    assign arb_valid_o = slot_valid;
    assign arb_data_o  = slot_data;
    assign arb_dir_o   = slot_dir;
    assign grant_o     = owner;

endmodule

// File: tb/tb_nx_stream_arbiter.sv
// Bench for nx_stream_arbiter: directed scenarios plus randomized traffic,
// all checked against a behavioural model of the arbitration rules.
module tb_nx_stream_arbiter;

    localparam int N  = 4;
    localparam int W  = 16;
    localparam int MB = 2;

    logic           clk;
    logic           rst;
    logic [N*W-1:0] in_data;
    logic [N*2-1:0] in_dir;
    logic [N-1:0]   in_valid;
    logic [N-1:0]   in_ready;
    logic [N-1:0]   mask;
    logic [W-1:0]   arb_data;
    logic [1:0]     arb_dir;
    logic           arb_valid;
    logic           arb_ready;
    logic [1:0]     grant;

    int checks   = 0;
    int failures = 0;

    int           m_owner;
    int           m_cnt;
    bit           m_valid;
    logic [W-1:0] m_data;
    logic [1:0]   m_dir;
    int           last_src;

    nx_stream_arbiter #(
        .STREAM_WIDTH(W),
        .INPUTS(N),
        .MAX_BURST(MB)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .in_data_i(in_data),
        .in_dir_i(in_dir),
        .in_valid_i(in_valid),
        .in_ready_o(in_ready),
        .mask_i(mask),
        .arb_data_o(arb_data),
        .arb_dir_o(arb_dir),
        .arb_valid_o(arb_valid),
        .arb_ready_i(arb_ready),
        .grant_o(grant)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Winner for this cycle: locked owner mid-burst, else first requester after owner.
    function automatic int model_pick(input logic [N-1:0] req);
        if (req[m_owner] && m_cnt > 0 && m_cnt < MB) return m_owner;
        for (int d = 1; d <= N; d++) begin
            if (req[(m_owner + d) % N]) return (m_owner + d) % N;
        end
        return -1;
    endfunction

    task automatic rand_data();
        for (int i = 0; i < N; i++) in_data[i*W +: W] = W'($urandom);
        in_dir = (2*N)'($urandom);
    endtask

    // Called just after a negedge with inputs set; returns at the next negedge.
    task automatic step();
        logic [N-1:0] req;
        logic [N-1:0] exp_rdy;
        bit           acc;
        int           s;
        #1;
        req     = in_valid & mask;
        acc     = !m_valid || arb_ready;
        s       = model_pick(req);
        exp_rdy = '0;
        if (!rst && acc && s >= 0) exp_rdy[s] = 1'b1;
        chk("in_ready", 64'(in_ready), 64'(exp_rdy));
        @(posedge clk);
        last_src = -1;
        if (rst) begin
            m_valid = 0; m_data = '0; m_dir = '0; m_owner = N - 1; m_cnt = 0;
        end else if (acc && s >= 0) begin
            m_cnt    = (s == m_owner && m_cnt > 0 && m_cnt < MB) ? m_cnt + 1 : 1;
            m_owner  = s;
            m_valid  = 1;
            m_data   = in_data[s*W +: W];
            m_dir    = in_dir[s*2 +: 2];
            last_src = s;
        end else begin
            if (acc) m_valid = 0;
            if (!req[m_owner]) m_cnt = 0;
        end
        #1;
        chk("arb_valid", 64'(arb_valid), 64'(m_valid));
        chk("grant", 64'(grant), 64'(m_owner));
        if (m_valid) begin
            chk("arb_data", 64'(arb_data), 64'(m_data));
            chk("arb_dir", 64'(arb_dir), 64'(m_dir));
        end
        @(negedge clk);
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        repeat (n) step();
        rst = 1'b0;
    endtask

    int exp_order [10] = '{0, 0, 1, 1, 2, 2, 3, 3, 0, 0};
    logic [W-1:0] hold_data;
    logic [1:0]   hold_dir;

    initial begin
        rst = 1'b1; in_valid = '0; mask = '1; arb_ready = 1'b1;
        in_data = '0; in_dir = '0;
        m_valid = 0; m_data = '0; m_dir = '0; m_owner = N - 1; m_cnt = 0; last_src = -1;
        @(negedge clk);

        // Reset state
        do_reset(2);
        chk("rst_valid", 64'(arb_valid), 64'd0);
        chk("rst_grant", 64'(grant), 64'd3);
        chk("rst_data", 64'(arb_data), 64'd0);
        chk("rst_ready", 64'(in_ready), 64'd0);

        // First request on input 1
        in_valid = 4'b0010; rand_data();
        step();
        chk("first_src", 64'(last_src), 64'd1);
        chk("first_grant", 64'(grant), 64'd1);
        in_valid = '0;
        step();
        chk("first_drain", 64'(arb_valid), 64'd0);

        // All inputs valid: bursts of two, rotating
        do_reset(1);
        in_valid = '1;
        for (int i = 0; i < 10; i++) begin
            rand_data();
            step();
            chk("all_order", 64'(grant), 64'(exp_order[i]));
            chk("all_nobubble", 64'(arb_valid), 64'd1);
        end

        // Sole requester re-wins at burst end without a bubble
        do_reset(1);
        in_valid = 4'b0100;
        for (int i = 0; i < 6; i++) begin
            rand_data();
            step();
            chk("solo_grant", 64'(grant), 64'd2);
            chk("solo_valid", 64'(arb_valid), 64'd1);
        end

        // Backpressure holds slot stable
        in_valid = '1;
        rand_data(); step();
        hold_data = arb_data; hold_dir = arb_dir;
        arb_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            rand_data();
            step();
            chk("bp_data", 64'(arb_data), 64'(hold_data));
            chk("bp_dir", 64'(arb_dir), 64'(hold_dir));
            chk("bp_ready", 64'(in_ready), 64'd0);
        end
        arb_ready = 1'b1;
        rand_data(); step();
        chk("bp_resume", 64'(arb_valid), 64'd1);

        // Mask clears input 0 after its first transfer
        do_reset(1);
        in_valid = 4'b0011; mask = '1;
        rand_data(); step();
        chk("mask_first", 64'(grant), 64'd0);
        mask = 4'b1110;
        for (int i = 0; i < 3; i++) begin
            rand_data();
            step();
            chk("mask_grant", 64'(grant), 64'd1);
            chk("mask_rdy0", 64'(in_ready[0]), 64'd0);
        end
        mask = '1;

        // Reset mid-burst with slot full
        in_valid = '1;
        rand_data(); step();
        arb_ready = 1'b0;
        rand_data(); step();
        do_reset(1);
        chk("midrst_valid", 64'(arb_valid), 64'd0);
        chk("midrst_grant", 64'(grant), 64'd3);
        arb_ready = 1'b1;
        rand_data(); step();
        chk("midrst_reaccept", 64'(grant), 64'd0);
        chk("midrst_valid2", 64'(arb_valid), 64'd1);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            in_valid  = N'($urandom);
            mask      = ($urandom_range(0, 3) == 0) ? N'($urandom) : '1;
            arb_ready = ($urandom_range(0, 3) != 0);
            rst       = ($urandom_range(0, 80) == 0);
            rand_data();
            step();
        end
        rst = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
